seq_divider: RTL
================

# seq_divider

Multi-cycle restoring integer divider, the inverse companion of the team's adder/multiplier arithmetic blocks. Accepts a dividend/divisor pair on a start strobe and produces quotient and remainder after WIDTH iteration cycles, one shift-subtract-restore step per clock. Supports signed (two's complement, truncating) and unsigned operation with divide-by-zero and signed-overflow flags. Sits beside the adders in the datapath as the DIV/REM execution unit.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
- a  input  WIDTH  dividend; captured with start
- b  input  WIDTH  divisor; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid
- Q  output  WIDTH  quotient; held until next accepted start
- R  output  WIDTH  remainder; held until next accepted start
- DivByZero  output  1  b was 0; valid with done, held
- Overflow  output  1  signed MIN/−1; valid with done, held

## Operation
- States: IDLE, RUN, FIX.
- IDLE: busy=0. On start=1: latch is_signed, sign bits, |a|, |b| (magnitudes only when is_signed=1; |MIN| = 2^(WIDTH−1) as unsigned), clear flags. If b==0 → FIX (skip RUN); else load counter=WIDTH, partial remainder=0, → RUN. busy=1 from next cycle.
- RUN: each cycle shift {rem, quo} left 1, bring in next dividend MSB; trial = rem − |b| (WIDTH+1 bits); if trial ≥ 0 keep it and set quotient LSB=1, else restore and set LSB=0. Decrement counter; after WIDTH steps → FIX.
- FIX: apply signs: Q negated if signs of a and b differ; R negated if a negative (R takes sign of dividend). Write Q, R, flags; done=1, busy=0; → IDLE.
- Divide by zero: Q = all ones, R = a (unmodified), DivByZero=1, Overflow=0 (independent of is_signed).
- Signed overflow (is_signed=1, a=MIN, b=−1): Q = MIN, R = 0, Overflow=1; the natural datapath result, flag from input compare at capture.
- Unsigned mode: no sign processing; Overflow always 0.
- start while busy=1: ignored, no effect on operation in flight.
- Inputs a, b, is_signed may change freely after capture.

## Timing
- Reset: state IDLE, busy=0, done=0, Q=0, R=0, DivByZero=0, Overflow=0, counter/internal registers 0.
- Start sampled at edge E0 → busy=1 during cycles after E0.
- Normal: RUN steps on edges E1..E_WIDTH, FIX on E_(WIDTH+1) → done=1 and results valid in the cycle after E_(WIDTH+1) (WIDTH+1 cycles after acceptance; 33 for WIDTH=32).
- Divide by zero: FIX on E1 → done in cycle after E1 (latency 1).
- done high exactly one cycle; busy=0 in that cycle, so start asserted with done is accepted (back-to-back, throughput one op per WIDTH+2 cycles).
- Reset mid-operation: aborts immediately, no done pulse, outputs return to reset values.
- Q/R/flags change only on FIX edge or reset.

## Test plan
- Unsigned 100 / 7 → Q=14, R=2, flags 0, done exactly 33 cycles after start edge, busy high 33 cycles.
- Signed −100 / 7 → Q=−14 (0xFFFFFFF2), R=−2 (0xFFFFFFFE); signed 100 / −7 → Q=−14, R=2; unsigned 0xFFFFFFFF / 1 → Q=0xFFFFFFFF, R=0.
- Signed 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0, Overflow=1; same operands unsigned → Q=0, R=0x80000000, Overflow=0.
- a=1234, b=0 (both modes) → Q=0xFFFFFFFF, R=1234, DivByZero=1, done 1 cycle after start.
- Start re-pulsed with 50/5 at cycle 10 of 100/7 → ignored, result 14/2; start held high on done cycle with 50/5 → accepted, second done 34 cycles after first with Q=10, R=0.
- rst asserted at cycle 15 of an operation → next cycle busy=0, Q=R=0, no done; fresh 9/4 afterward → Q=2, R=1.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift-subtract-restore step per clock,
// signed (truncating) or unsigned, with divide-by-zero and signed-overflow flags.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivByZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dz_out_q, dz_out_d;
  logic             ov_out_q, ov_out_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Negating MIN yields MIN, which reads correctly as 2^(WIDTH-1) unsigned.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, bmag_q};
  assign borrow  = trial[WIDTH+1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    done_d   = 1'b0;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dz_out_d = dz_out_q;
    ov_out_d = ov_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bmag_d = b_mag;
          if (b == '0) begin
            // Route the zero-divisor result through FIX unchanged: Q=all ones, R=a.
            rem_d   = a;
            quo_d   = '1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = 1'b0;
            ov_d    = is_signed && (a == MIN_VAL) && (b == '1);
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_out_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
        r_out_d  = rneg_q ? (~rem_q + 1'b1) : rem_q;
        dz_out_d = dz_q;
        ov_out_d = ov_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dz_out_q <= 1'b0;
      ov_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dz_out_q <= dz_out_d;
      ov_out_q <= ov_out_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign Q         = q_out_q;
  assign R         = r_out_q;
  assign DivByZero = dz_out_q;
  assign Overflow  = ov_out_q;

endmodule
